// File: rtl/param_pushdown_stack_if.sv
// Host-side bundle for the push-down stack: op requests in, popped data and status out.
interface param_pushdown_stack_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 10
);
   logic                  CS_i;
   logic                  Push_i;
   logic                  Pop_i;
   logic                  ErrClr_i;
   logic [DATA_WIDTH-1:0] Data_i;
   logic [DATA_WIDTH-1:0] Data_o;
   logic                  Valid_o;
   logic [ADDR_WIDTH:0]   Count_o;
   logic                  Full_o;
   logic                  Empty_o;
   logic                  Overflow_o;
   logic                  Underflow_o;

   modport master (
      output CS_i, Push_i, Pop_i, ErrClr_i, Data_i,
      input  Data_o, Valid_o, Count_o, Full_o, Empty_o, Overflow_o, Underflow_o
   );

   modport slave (
      input  CS_i, Push_i, Pop_i, ErrClr_i, Data_i,
      output Data_o, Valid_o, Count_o, Full_o, Empty_o, Overflow_o, Underflow_o
   );
endinterface

// File: rtl/param_pushdown_stack.sv
// LIFO stack over a 2**ADDR_WIDTH entry array; registered pop path, replace-top on push+pop,
// sticky overflow/underflow flags.
module param_pushdown_stack #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  Clk_i,
   input  logic                  Rst_i,
   param_pushdown_stack_if.slave bus
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;

   typedef logic [ADDR_WIDTH:0]   cnt_t;
   typedef logic [ADDR_WIDTH-1:0] addr_t;
   typedef logic [DATA_WIDTH-1:0] data_t;

   typedef enum logic [2:0] {
      OP_NONE,
      OP_PUSH,
      OP_POP,
      OP_REPL,
      OP_PUSH_UNF,
      OP_OVF,
      OP_UNF
   } op_e;

   localparam addr_t ONE_A = addr_t'(1);
   localparam cnt_t  ONE_C = cnt_t'(1);
   localparam cnt_t  FULL_C = cnt_t'(DEPTH);

   data_t mem_q [DEPTH];

   cnt_t  count_q, count_d;
   data_t data_q, data_d;
   logic  valid_q, valid_d;
   logic  ovf_q, ovf_d;
   logic  unf_q, unf_d;

   op_e   op;
   logic  full, empty;
   addr_t sp_addr, top_addr;
   logic  wr_en;
   addr_t wr_addr;

   assign full     = (count_q == FULL_C);
   assign empty    = (count_q == '0);
   assign sp_addr  = count_q[ADDR_WIDTH-1:0];
   assign top_addr = sp_addr - ONE_A;

   // Decode on the pre-edge count; push+pop on empty degenerates to a push.
   always_comb begin
      op = OP_NONE;
      if (bus.CS_i) begin
         unique case ({bus.Push_i, bus.Pop_i})
            2'b11:   op = empty ? OP_PUSH_UNF : OP_REPL;
            2'b10:   op = full  ? OP_OVF      : OP_PUSH;
            2'b01:   op = empty ? OP_UNF      : OP_POP;
            default: op = OP_NONE;
         endcase
      end
   end

   always_comb begin
      count_d = count_q;
      data_d  = data_q;
      valid_d = 1'b0;
      ovf_d   = bus.ErrClr_i ? 1'b0 : ovf_q;
      unf_d   = bus.ErrClr_i ? 1'b0 : unf_q;
      wr_en   = 1'b0;
      wr_addr = sp_addr;
      unique case (op)
         OP_PUSH: begin
            wr_en   = 1'b1;
            count_d = count_q + ONE_C;
         end
         OP_POP: begin
            data_d  = mem_q[top_addr];
            valid_d = 1'b1;
            count_d = count_q - ONE_C;
         end
         OP_REPL: begin
            // Read and write the same slot; the register captures the old top.
            data_d  = mem_q[top_addr];
            valid_d = 1'b1;
            wr_en   = 1'b1;
            wr_addr = top_addr;
         end
         OP_PUSH_UNF: begin
            wr_en   = 1'b1;
            count_d = count_q + ONE_C;
            unf_d   = 1'b1;
         end
         OP_OVF:  ovf_d = 1'b1;
         OP_UNF:  unf_d = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge Clk_i or posedge Rst_i) begin
      if (Rst_i) begin
         count_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   // Storage is not reset; entries above the pointer are never observable.
   always_ff @(posedge Clk_i) begin
      if (wr_en && !Rst_i) mem_q[wr_addr] <= bus.Data_i;
   end

   assign bus.Data_o      = data_q;
   assign bus.Valid_o     = valid_q;
   assign bus.Count_o     = count_q;
   assign bus.Full_o      = full;
   assign bus.Empty_o     = empty;
   assign bus.Overflow_o  = ovf_q;
   assign bus.Underflow_o = unf_q;
endmodule
